fpu_addsub_param: RTL and testbench

- Parametrised successor of the team's multi-cycle floating-point adder.
- Operand format is configurable: 1 sign bit, EXP_W exponent bits, MAN_W fraction bits.
- Adds a selectable subtract mode, valid/ready handshakes on both sides, guard/round/sticky alignment and round-to-nearest-even.
- Sits between the operand register file and the result writeback stage. It processes one operation at a time.

---
 rtl/fpu_pkg.sv | 20 ++
 rtl/fpu_align_shift.sv | 29 ++
 rtl/fpu_addsub_param.sv | 203 ++++++++++++++++++++
 tb/tb_fpu_addsub_param.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the parametrised floating-point add/subtract unit.
package fpu_pkg;

  typedef enum logic [1:0] {
    OVERFLOW  = 2'd0,
    UNDERFLOW = 2'd1,
    EXACT     = 2'd2,
    INEXACT   = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    OPERATE,
    NORMALIZE,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fpu_align_shift.sv
// Combinational right shifter; every bit shifted out is ORed into bit 0 (sticky).
module fpu_align_shift #(
  parameter int WIDTH = 25,
  parameter int SH_W  = 10
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [SH_W-1:0]  shamt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [31:0]      shamt_ext;
  logic [WIDTH-1:0] lost_mask;

  assign shamt_ext = 32'(shamt_i);

  always_comb begin
    lost_mask = '0;
    data_o    = '0;
    if (shamt_ext >= 32'(WIDTH - 1)) begin
      // Nothing but the sticky bit survives a shift this far.
      data_o = {{(WIDTH-1){1'b0}}, |data_i};
    end else begin
      lost_mask = ~({WIDTH{1'b1}} << shamt_i);
      data_o    = data_i >> shamt_i;
      data_o[0] = data_o[0] | (|(data_i & lost_mask));
    end
  end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point add/subtract with GRS alignment and round-to-nearest-even.
// state     | meaning
// IDLE      | ready for operands; larger magnitude is latched as A
// ALIGN     | B shifted right by the exponent difference, sticky collected
// OPERATE   | mantissa add/subtract; exact zero skips to DONE
// NORMALIZE | one left shift per cycle until the hidden bit is set
// ROUND     | nearest-even rounding, overflow detection, result packing
// DONE      | result held until out_ready
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W = 10,
  parameter  int MAN_W = 21,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clock_100Khz,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op_sub,
  input  logic [W-1:0] Op_A_in,
  input  logic [W-1:0] Op_B_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output status_t      status_out
);

  localparam int                M          = MAN_W + 4;
  localparam int                NCNT_W     = $clog2(M + 1);
  localparam logic [EXP_W:0]    EXP_MAX    = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0]    EXP_ONE    = (EXP_W+1)'(1);
  localparam logic [NCNT_W-1:0] NSHIFT_MAX = NCNT_W'(MAN_W + 3);

  state_t             state_q, state_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [EXP_W:0]     exp_a_q, exp_a_d;
  logic [EXP_W-1:0]   exp_b_q, exp_b_d;
  logic [M-1:0]       man_a_q, man_a_d, man_b_q, man_b_d;
  logic [NCNT_W-1:0]  nshift_q, nshift_d;
  logic [W-1:0]       data_q, data_d;
  status_t            status_q, status_d;

  logic               sgn_b_eff, swap, inc, inexact;
  logic [EXP_W-1:0]   exp_diff;
  logic [M-1:0]       man_b_shifted;
  logic [M:0]         sum;
  logic [MAN_W+1:0]   rounded;
  logic [EXP_W:0]     exp_rnd;
  logic [MAN_W-1:0]   frac_rnd;

  // Zero exponent means zero: the stored fraction is discarded.
  function automatic logic [M-1:0] unpack_man(input logic [W-2:0] mag);
    return (|mag[W-2:MAN_W]) ? {1'b1, mag[MAN_W-1:0], 3'b000} : '0;
  endfunction

  assign exp_diff = exp_a_q[EXP_W-1:0] - exp_b_q;

  fpu_align_shift #(.WIDTH(M), .SH_W(EXP_W)) u_align (
    .data_i  (man_b_q),
    .shamt_i (exp_diff),
    .data_o  (man_b_shifted)
  );

  always_comb begin
    state_d   = state_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    exp_a_d   = exp_a_q;
    exp_b_d   = exp_b_q;
    man_a_d   = man_a_q;
    man_b_d   = man_b_q;
    nshift_d  = nshift_q;
    data_d    = data_q;
    status_d  = status_q;
    sgn_b_eff = Op_B_in[W-1] ^ op_sub;
    swap      = Op_B_in[W-2:0] > Op_A_in[W-2:0];
    sum       = '0;
    inc       = 1'b0;
    inexact   = 1'b0;
    rounded   = '0;
    exp_rnd   = '0;
    frac_rnd  = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (swap) begin
            sign_a_d = sgn_b_eff;
            sign_b_d = Op_A_in[W-1];
            exp_a_d  = {1'b0, Op_B_in[W-2:MAN_W]};
            exp_b_d  = Op_A_in[W-2:MAN_W];
            man_a_d  = unpack_man(Op_B_in[W-2:0]);
            man_b_d  = unpack_man(Op_A_in[W-2:0]);
          end else begin
            sign_a_d = Op_A_in[W-1];
            sign_b_d = sgn_b_eff;
            exp_a_d  = {1'b0, Op_A_in[W-2:MAN_W]};
            exp_b_d  = Op_B_in[W-2:MAN_W];
            man_a_d  = unpack_man(Op_A_in[W-2:0]);
            man_b_d  = unpack_man(Op_B_in[W-2:0]);
          end
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        man_b_d = man_b_shifted;
        state_d = OPERATE;
      end
      OPERATE: begin
        if (sign_a_q == sign_b_q) begin
          sum = {1'b0, man_a_q} + {1'b0, man_b_q};
          if (sum[M]) begin
            man_a_d = {sum[M:2], sum[1] | sum[0]};
            exp_a_d = exp_a_q + EXP_ONE;
          end else begin
            man_a_d = sum[M-1:0];
          end
        end else begin
          // A is the larger magnitude, so this never borrows.
          sum     = {1'b0, man_a_q} - {1'b0, man_b_q};
          man_a_d = sum[M-1:0];
        end
        if (sum == '0) begin
          data_d   = '0;
          status_d = EXACT;
          state_d  = DONE;
        end else begin
          nshift_d = '0;
          state_d  = NORMALIZE;
        end
      end
      NORMALIZE: begin
        if (man_a_q[M-1]) begin
          state_d = ROUND;
        end else if (exp_a_q > EXP_ONE && nshift_q < NSHIFT_MAX) begin
          man_a_d  = man_a_q << 1;
          exp_a_d  = exp_a_q - EXP_ONE;
          nshift_d = nshift_q + NCNT_W'(1);
        end else begin
          data_d   = {sign_a_q, {(W-1){1'b0}}};
          status_d = UNDERFLOW;
          state_d  = DONE;
        end
      end
      ROUND: begin
        inc     = man_a_q[2] & (man_a_q[1] | man_a_q[0] | man_a_q[3]);
        inexact = |man_a_q[2:0];
        rounded = {1'b0, man_a_q[M-1:3]} + (MAN_W+2)'(inc);
        if (rounded[MAN_W+1]) begin
          exp_rnd  = exp_a_q + EXP_ONE;
          frac_rnd = rounded[MAN_W:1];
        end else begin
          exp_rnd  = exp_a_q;
          frac_rnd = rounded[MAN_W-1:0];
        end
        if (exp_rnd >= EXP_MAX) begin
          data_d   = {sign_a_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          status_d = OVERFLOW;
        end else begin
          data_d   = {sign_a_q, exp_rnd[EXP_W-1:0], frac_rnd};
          status_d = inexact ? INEXACT : EXACT;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      man_a_q  <= '0;
      man_b_q  <= '0;
      nshift_q <= '0;
      data_q   <= '0;
      status_q <= EXACT;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      man_a_q  <= man_a_d;
      man_b_q  <= man_b_d;
      nshift_q <= nshift_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign data_out   = data_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Directed-vector bench for fpu_addsub_param (EXP_W=10, MAN_W=21).
module tb_fpu_addsub_param;
  import fpu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] Op_A_in;
  logic [31:0] Op_B_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  status_t     status_out;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp_data;
    status_t     exp_st;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs[NVEC];

  fpu_addsub_param #(.EXP_W(10), .MAN_W(21)) dut (
    .clock_100Khz (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_sub       (op_sub),
    .Op_A_in      (Op_A_in),
    .Op_B_in      (Op_B_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .status_out   (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one operation from IDLE; returns cycles until out_valid (acceptance edge counts as 1).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, output int lat);
    Op_A_in  = a;
    Op_B_in  = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (out_valid && in_ready) begin
        failures++;
        $display("FAIL vld_rdy_excl: out_valid=%0b in_ready=%0b required not both 1", out_valid, in_ready);
      end
    end
  end

  initial begin
    int lat;
    logic [31:0] held;

    vecs[0]  = '{"add_exact",   32'h3FE00000, 32'h3FE00000, 1'b0, 32'h40000000, EXACT,    5};
    vecs[1]  = '{"add_carry",   32'h3FF00000, 32'h3FE00000, 1'b0, 32'h40080000, EXACT,    5};
    vecs[2]  = '{"sub_norm",    32'h3FE00000, 32'h3FF00000, 1'b1, 32'hBFC00000, EXACT,    6};
    vecs[3]  = '{"cancel",      32'h3FE00000, 32'h3FE00000, 1'b1, 32'h00000000, EXACT,    3};
    vecs[4]  = '{"rnd_tie_even",32'h3FE00000, 32'h3D200000, 1'b0, 32'h3FE00000, INEXACT,  5};
    vecs[5]  = '{"overflow",    32'h7FC00000, 32'h7FC00000, 1'b0, 32'h7FE00000, OVERFLOW, 5};
    vecs[6]  = '{"add_zero",    32'h3FE00000, 32'h00000000, 1'b0, 32'h3FE00000, EXACT,    5};
    vecs[7]  = '{"one_ulp",     32'h3FE00000, 32'h3D400000, 1'b0, 32'h3FE00001, EXACT,    5};
    vecs[8]  = '{"rnd_tie_odd", 32'h3FE00001, 32'h3D200000, 1'b0, 32'h3FE00002, INEXACT,  5};
    vecs[9]  = '{"sticky_far",  32'h3FE00000, 32'h00200000, 1'b0, 32'h3FE00000, INEXACT,  5};
    vecs[10] = '{"deep_norm",   32'h3FE00001, 32'h3FE00000, 1'b1, 32'h3D400000, EXACT,   26};
    vecs[11] = '{"neg_add",     32'hBFE00000, 32'hBFE00000, 1'b0, 32'hC0000000, EXACT,    5};
    vecs[12] = '{"sub_of_neg",  32'h3FE00000, 32'hBFE00000, 1'b1, 32'h40000000, EXACT,    5};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_sub    = 1'b0;
    Op_A_in   = '0;
    Op_B_in   = '0;
    #12;
    chk("rst_data",      data_out,              32'h0);
    chk("rst_status",    32'(status_out),       32'(EXACT));
    chk("rst_out_valid", 32'(out_valid),        32'h0);
    chk("rst_in_ready",  32'(in_ready),         32'h1);
    #5 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk({vecs[i].name, "_data"},   data_out,         vecs[i].exp_data);
      chk({vecs[i].name, "_status"}, 32'(status_out),  32'(vecs[i].exp_st));
      chk({vecs[i].name, "_lat"},    32'(lat),         32'(vecs[i].exp_lat));
      release_result();
    end

    // Result must hold while the consumer stalls.
    run_op(32'h3FF00000, 32'h3FE00000, 1'b0, lat);
    held = data_out;
    chk("stall_first_data", held, 32'h40080000);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("stall_data",      data_out,        32'h40080000);
      chk("stall_out_valid", 32'(out_valid),  32'h1);
      chk("stall_in_ready",  32'(in_ready),   32'h0);
    end
    release_result();
    chk("stall_release_in_ready",  32'(in_ready),  32'h1);
    chk("stall_release_out_valid", 32'(out_valid), 32'h0);

    // Reset asserted while the long normalisation is in progress.
    Op_A_in  = 32'h3FE00001;
    Op_B_in  = 32'h3FE00000;
    op_sub   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("midop_busy", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    chk("midrst_data",      data_out,        32'h0);
    chk("midrst_status",    32'(status_out), 32'(EXACT));
    chk("midrst_out_valid", 32'(out_valid),  32'h0);
    chk("midrst_in_ready",  32'(in_ready),   32'h1);
    #3 reset = 1'b1;
    for (int k = 0; k < 30; k++) @(posedge clk);
    #1;
    chk("midrst_discarded", 32'(out_valid), 32'h0);

    run_op(32'h3FE00000, 32'h3FE00000, 1'b0, lat);
    chk("recover_data",   data_out,        32'h40000000);
    chk("recover_status", 32'(status_out), 32'(EXACT));
    chk("recover_lat",    32'(lat),        32'd5);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
